aq_cp0_sync_arb: RTL and testbench

- Arbitrates three CP0 requesters for the single LSU sync handshake (cp0_lsu_sync_req / lsu_cp0_sync_ack).
- Requesters:
  - low-power-mode (WFI) sequencer
  - fence unit
  - cache-maintenance-op unit
- Sits between those requesters and the LSU. Only one sync is outstanding at a time; the winner gets a one-cycle ack.
- Round-robin priority, flush abort, and a sticky watchdog for a hung LSU.

---
 rtl/aq_cp0_sync_arb.sv | 169 ++++++++++++++++
 tb/tb_aq_cp0_sync_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aq_cp0_sync_arb.sv
// aq_cp0_sync_arb
// Arbitrates three CP0 requesters (low-power sequencer, fence unit and
// cache-maintenance unit) for the single LSU sync handshake. Only one sync
// is outstanding at a time. The winner receives a one-cycle ack. Priority
// is round-robin. A pipeline flush aborts the sync in progress, and a
// sticky watchdog flags an LSU that never answers.
//
// Ports:
//   forever_cpuclk         free-running CPU clock
//   cpurst_b               async active-low reset
//   rtu_yy_xx_flush        pipeline flush, aborts any sync in progress
//   special_lpmd_sync_req  requester 0 (lpmd), level
//   fence_sync_req         requester 1 (fence), level
//   cmo_sync_req           requester 2 (cache op), level
//   lsu_cp0_sync_ack       LSU drained/synced, level (only looked at in REQ)
//   timeout_clr            clears the sticky timeout flag
//   cp0_lsu_sync_req       sync request to the LSU
//   lpmd_sync_ack          one-cycle ack to requester 0
//   fence_sync_ack         one-cycle ack to requester 1
//   cmo_sync_ack           one-cycle ack to requester 2
//   sync_arb_grant         one-hot current grant, bit i = requester i
//   sync_arb_busy          arbiter not idle
//   sync_arb_timeout       sticky watchdog flag
module aq_cp0_sync_arb #(
  parameter int TO_WIDTH = 10,
  parameter int TO_LIMIT = 1023
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst_b,
  input  logic       rtu_yy_xx_flush,
  input  logic       special_lpmd_sync_req,
  input  logic       fence_sync_req,
  input  logic       cmo_sync_req,
  input  logic       lsu_cp0_sync_ack,
  input  logic       timeout_clr,
  output logic       cp0_lsu_sync_req,
  output logic       lpmd_sync_ack,
  output logic       fence_sync_ack,
  output logic       cmo_sync_ack,
  output logic [2:0] sync_arb_grant,
  output logic       sync_arb_busy,
  output logic       sync_arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ACK  = 2'b10,
    GAP  = 2'b11
  } state_e;

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TO_LIMIT);

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic [2:0]          reqs;
  logic [2:0]          pick;
  logic [TO_WIDTH-1:0] cnt_inc;
  logic                granted_req;

  assign reqs        = {cmo_sync_req, fence_sync_req, special_lpmd_sync_req};
  assign granted_req = |(grant_q & reqs);
  assign cnt_inc     = (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;

  // Rotating priority scan starting at rr_ptr; first high request wins.
  always_comb begin
    pick = 3'b000;
    case (rr_ptr_q)
      2'd1: begin
        if      (reqs[1]) pick = 3'b010;
        else if (reqs[2]) pick = 3'b100;
        else if (reqs[0]) pick = 3'b001;
      end
      2'd2: begin
        if      (reqs[2]) pick = 3'b100;
        else if (reqs[0]) pick = 3'b001;
        else if (reqs[1]) pick = 3'b010;
      end
      default: begin
        if      (reqs[0]) pick = 3'b001;
        else if (reqs[1]) pick = 3'b010;
        else if (reqs[2]) pick = 3'b100;
      end
    endcase
  end

  // Next-state logic. Flush beats everything; in REQ a withdrawal beats an
  // LSU ack arriving in the same cycle. The watchdog counter only runs in
  // REQ, so it always restarts from zero for each new request.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = '0;
    case (state_q)
      IDLE: begin
        if (|reqs) begin
          grant_d = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (!granted_req) begin
          grant_d = 3'b000;
          state_d = IDLE;
        end else if (lsu_cp0_sync_ack) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if      (grant_q[0]) rr_ptr_d = 2'd1;
        else if (grant_q[1]) rr_ptr_d = 2'd2;
        else                 rr_ptr_d = 2'd0;
        grant_d = 3'b000;
        state_d = GAP;
      end
      default: begin
        grant_d = 3'b000;
        state_d = IDLE;
      end
    endcase
    if (rtu_yy_xx_flush) begin
      state_d  = IDLE;
      grant_d  = 3'b000;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = '0;
    end
  end

  // Sticky watchdog: set while REQ holds the counter at its limit, and a
  // set in the same cycle as a clear keeps the flag high.
  always_comb begin
    timeout_d = timeout_q & ~timeout_clr;
    if (state_q == REQ && cnt_inc == LIMIT) timeout_d = 1'b1;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= IDLE;
      grant_q   <= 3'b000;
      rr_ptr_q  <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign cp0_lsu_sync_req = (state_q == REQ);
  assign sync_arb_busy    = (state_q != IDLE);
  assign sync_arb_grant   = grant_q;
  assign sync_arb_timeout = timeout_q;

  // A flush in the ACK cycle must suppress the ack in that same cycle, so
  // flush is the one input allowed to reach the ack outputs directly.
  assign lpmd_sync_ack  = (state_q == ACK) & grant_q[0] & ~rtu_yy_xx_flush;
  assign fence_sync_ack = (state_q == ACK) & grant_q[1] & ~rtu_yy_xx_flush;
  assign cmo_sync_ack   = (state_q == ACK) & grant_q[2] & ~rtu_yy_xx_flush;

endmodule

// File: tb/tb_aq_cp0_sync_arb.sv
// Testbench for aq_cp0_sync_arb.
// Each table record holds the inputs for one clock cycle and the outputs
// expected during that cycle. The record fields are:
//   in  = {reset, lpmd, fence, cmo, lsuAck, flush, clr}
//   out = {grant[2:0], syncReq, ackLpmd, ackFence, ackCmo, busy, timeout}
// Inputs are driven on the falling edge. The expected outputs go into a
// queue, and the outputs are sampled 1 ns later.
module tb_aq_cp0_sync_arb;

  logic       clock;
  logic       cpuRstB;
  logic       flush;
  logic       lpmdReq;
  logic       fenceReq;
  logic       cmoReq;
  logic       lsuAck;
  logic       timeoutClr;
  logic       syncReq;
  logic       lpmdAck;
  logic       fenceAck;
  logic       cmoAck;
  logic [2:0] grant;
  logic       busy;
  logic       timeout;

  typedef struct {
    string      tag;
    logic [6:0] in;
    logic [8:0] out;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] expQ[$];
  int         total = 0;
  int         bad   = 0;

  aq_cp0_sync_arb #(
    .TO_WIDTH(3),
    .TO_LIMIT(4)
  ) dut (
    .forever_cpuclk       (clock),
    .cpurst_b             (cpuRstB),
    .rtu_yy_xx_flush      (flush),
    .special_lpmd_sync_req(lpmdReq),
    .fence_sync_req       (fenceReq),
    .cmo_sync_req         (cmoReq),
    .lsu_cp0_sync_ack     (lsuAck),
    .timeout_clr          (timeoutClr),
    .cp0_lsu_sync_req     (syncReq),
    .lpmd_sync_ack        (lpmdAck),
    .fence_sync_ack       (fenceAck),
    .cmo_sync_ack         (cmoAck),
    .sync_arb_grant       (grant),
    .sync_arb_busy        (busy),
    .sync_arb_timeout     (timeout)
  );

  // 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input string tag, input logic [6:0] in, input logic [8:0] out);
    vec_t v;
    v.tag = tag;
    v.in  = in;
    v.out = out;
    return v;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue its expectation.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    cpuRstB    = ~v.in[6];
    lpmdReq    = v.in[5];
    fenceReq   = v.in[4];
    cmoReq     = v.in[3];
    lsuAck     = v.in[2];
    flush      = v.in[1];
    timeoutClr = v.in[0];
    expQ.push_back(v.out);
  endtask

  // Sample away from the rising edge and compare against the queued value.
  task automatic checkOutput(input int idx, input string tag);
    logic [8:0] act;
    logic [8:0] exp;
    #1;
    act = {grant, syncReq, lpmdAck, fenceAck, cmoAck, busy, timeout};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %b but no expectation queued", tag, idx, act);
    end else begin
      exp = expQ.pop_front();
      if (act !== exp) begin
        bad++;
        $display("[TB] FAIL %s step %0d: got {grant,req,ackL,ackF,ackC,busy,tmo}=%b required %b",
                 tag, idx, act, exp);
      end
    end
  endtask

  initial begin
    cpuRstB    = 1'b0;
    flush      = 1'b0;
    lpmdReq    = 1'b0;
    fenceReq   = 1'b0;
    cmoReq     = 1'b0;
    lsuAck     = 1'b0;
    timeoutClr = 1'b0;

    // All three requesters held from reset, LSU ack tied high.
    vecs.push_back(mk("rr", 7'b1_111_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b001_0_100_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b010_0_010_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b100_1_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b100_0_001_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("rr", 7'b0_111_1_0_0, 9'b001_0_100_1_0));
    vecs.push_back(mk("rr", 7'b0_000_0_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("rr", 7'b0_000_0_0_0, 9'b000_0_000_0_0));

    // Single fence request. The LSU acks in cycle 3, and the fence ack
    // follows in cycle 4. Next, fence and cmo both request; a pointer at 2
    // must pick cmo.
    vecs.push_back(mk("single", 7'b1_000_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("single", 7'b0_010_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("single", 7'b0_010_0_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("single", 7'b0_010_0_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("single", 7'b0_010_1_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("single", 7'b0_010_0_0_0, 9'b010_0_010_1_0));
    vecs.push_back(mk("single", 7'b0_000_0_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("single", 7'b0_011_1_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("single", 7'b0_011_1_0_0, 9'b100_1_000_1_0));
    vecs.push_back(mk("single", 7'b0_010_0_0_0, 9'b100_0_001_1_0));
    vecs.push_back(mk("single", 7'b0_000_0_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("single", 7'b0_000_0_0_0, 9'b000_0_000_0_0));

    // Flush in the ACK cycle masks the ack and leaves the pointer at 0, so
    // lpmd beats fence on the next arbitration.
    vecs.push_back(mk("flush", 7'b1_000_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("flush", 7'b0_100_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("flush", 7'b0_100_1_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("flush", 7'b0_100_0_1_0, 9'b001_0_000_1_0));
    vecs.push_back(mk("flush", 7'b0_110_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("flush", 7'b0_000_0_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("flush", 7'b0_000_0_0_0, 9'b000_0_000_0_0));

    // cmo withdraws in REQ while the LSU acks. Withdrawal wins, and the
    // pending fence request is granted next.
    vecs.push_back(mk("withdraw", 7'b1_000_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("withdraw", 7'b0_001_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("withdraw", 7'b0_010_1_0_0, 9'b100_1_000_1_0));
    vecs.push_back(mk("withdraw", 7'b0_010_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("withdraw", 7'b0_010_1_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("withdraw", 7'b0_010_0_0_0, 9'b010_0_010_1_0));
    vecs.push_back(mk("withdraw", 7'b0_000_0_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("withdraw", 7'b0_000_0_0_0, 9'b000_0_000_0_0));

    // Watchdog with a limit of 4. The flag appears after the fourth REQ
    // cycle. A clear together with a set keeps the flag; a clear alone drops
    // it. Then the pointer is moved to 2, reset is asserted during REQ, and
    // arbitration must restart from pointer 0.
    vecs.push_back(mk("wdog", 7'b1_000_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_0, 9'b001_1_000_1_0));
    vecs.push_back(mk("wdog", 7'b0_100_0_0_1, 9'b001_1_000_1_1));
    vecs.push_back(mk("wdog", 7'b0_000_0_0_0, 9'b001_1_000_1_1));
    vecs.push_back(mk("wdog", 7'b0_000_0_0_1, 9'b000_0_000_0_1));
    vecs.push_back(mk("wdog", 7'b0_010_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rstreq", 7'b0_010_1_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("rstreq", 7'b0_010_0_0_0, 9'b010_0_010_1_0));
    vecs.push_back(mk("rstreq", 7'b0_000_0_0_0, 9'b000_0_000_1_0));
    vecs.push_back(mk("rstreq", 7'b0_001_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rstreq", 7'b0_001_0_0_0, 9'b100_1_000_1_0));
    vecs.push_back(mk("rstreq", 7'b1_011_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rstreq", 7'b0_011_0_0_0, 9'b000_0_000_0_0));
    vecs.push_back(mk("rstreq", 7'b0_000_0_0_0, 9'b010_1_000_1_0));
    vecs.push_back(mk("rstreq", 7'b0_000_0_0_0, 9'b000_0_000_0_0));

    $display("[TB] applying %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i].tag);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
